key_bit_serializer: RTL and testbench

Upstream input stage for the 1101 string detector and its 8-digit scanning display. It turns a raw bit switch and a raw push button into a clean serial bit stream. Each debounced button press captures the switch level into an 8-entry FIFO. The FIFO is drained one bit per 1 Hz tick from the frequency divider, presenting D to the detector and display shift register.

---
 rtl/key_bit_serializer_if.sv | 24 ++
 rtl/key_bit_serializer.sv | 153 +++++++++++++++
 tb/tb_key_bit_serializer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_bit_serializer_if.sv
// Stream-side bundle of the key bit serializer: the divider tick in, and the
// serial bit plus FIFO status out to the detector/display.
interface key_bit_serializer_if #(
   parameter int DEPTH = 8
);
   logic                     TICK;
   logic                     D;
   logic                     D_VALID;
   logic [$clog2(DEPTH):0]   FIFO_CNT;
   logic                     EMPTY;
   logic                     FULL;
   logic                     OVF;

   // master = the serializer, slave = the detector/display side
   modport master (
      input  TICK,
      output D, D_VALID, FIFO_CNT, EMPTY, FULL, OVF
   );

   modport slave (
      output TICK,
      input  D, D_VALID, FIFO_CNT, EMPTY, FULL, OVF
   );
endinterface

// File: rtl/key_bit_serializer.sv
// Switch + push-button front end: synchronize, debounce the button, queue one
// switch sample per press, and release one queued bit per divider tick.
module key_bit_serializer #(
   parameter int DEB_CYCLES = 500000,
   parameter int DEPTH      = 8
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  KEY_BIT,
   input  logic                  KEY_PUSH,
   key_bit_serializer_if.master  bus
);

   localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_EMPTY = '0;

   // ------------------------------------------------------------------
   // Two-flop synchronizers; the button idles released (high).
   // ------------------------------------------------------------------
   logic bit_meta, bit_sync;
   logic push_meta, push_sync;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its inputs as they were before this edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bit_meta  <= 1'b0;
         bit_sync  <= 1'b0;
         push_meta <= 1'b1;
         push_sync <= 1'b1;
      end else begin
         bit_meta  <= KEY_BIT;
         bit_sync  <= bit_meta;
         push_meta <= KEY_PUSH;
         push_sync <= push_meta;
      end
   end

   // ------------------------------------------------------------------
   // Debouncer: the synced level must differ from btn for DEB_CYCLES
   // consecutive cycles before btn follows it.
   // ------------------------------------------------------------------
   logic             btn;
   logic             btn_d;
   logic [DEB_W-1:0] deb_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         btn     <= 1'b1;
         btn_d   <= 1'b1;
         deb_cnt <= '0;
      end else begin
         btn_d <= btn;
         if (push_sync == btn) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            btn     <= push_sync;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   // One-cycle pulse on the released-to-pressed transition only.
   logic press_evt;
   assign press_evt = btn_d & ~btn;

   // ------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------
   logic             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             do_pop, do_push, drop;
   logic             d_q, d_valid_q, empty_q, full_q, ovf_q;

   // A pop frees the slot a simultaneous push needs, so a full FIFO still
   // accepts a press coincident with a tick.
   assign do_pop  = bus.TICK && (cnt != CNT_EMPTY);
   assign do_push = press_evt && ((cnt != CNT_FULL) || do_pop);
   assign drop    = press_evt && (cnt == CNT_FULL) && !do_pop;

   // NOTE: give every always_comb output a default before any branch so no
   // path leaves it unassigned and infers a latch.
   always_comb begin
      cnt_nxt = cnt;
      unique case ({do_push, do_pop})
         2'b10:   cnt_nxt = cnt + 1'b1;
         2'b01:   cnt_nxt = cnt - 1'b1;
         default: cnt_nxt = cnt;
      endcase
   end

   // NOTE: the storage array has no reset; cnt gates every read, so stale
   // contents are never observed and the array can map onto plain RAM.
   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem[wr_ptr] <= bit_sync;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         d_q       <= 1'b0;
         d_valid_q <= 1'b0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         empty_q <= (cnt_nxt == CNT_EMPTY);
         full_q  <= (cnt_nxt == CNT_FULL);

         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end

         // When full, wr_ptr == rd_ptr; the read below sees the old entry
         // while the coincident push overwrites that slot.
         if (bus.TICK) begin
            if (do_pop) begin
               d_q       <= mem[rd_ptr];
               d_valid_q <= 1'b1;
               rd_ptr    <= rd_ptr + 1'b1;
            end else begin
               d_q       <= 1'b0;
               d_valid_q <= 1'b0;
            end
         end

         if (drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign bus.D        = d_q;
   assign bus.D_VALID  = d_valid_q;
   assign bus.FIFO_CNT = cnt;
   assign bus.EMPTY    = empty_q;
   assign bus.FULL     = full_q;
   assign bus.OVF      = ovf_q;

endmodule

// File: tb/tb_key_bit_serializer.sv
// Self-checking bench for key_bit_serializer (DEB_CYCLES=4, DEPTH=8): directed
// latency/boundary sequences, a vector table, and random traffic vs a queue model.
module tb_key_bit_serializer;

   localparam int DEB   = 4;
   localparam int DEPTH = 8;

   logic CLK      = 1'b0;
   logic RST_N    = 1'b0;
   logic KEY_BIT  = 1'b0;
   logic KEY_PUSH = 1'b1;

   key_bit_serializer_if #(.DEPTH(DEPTH)) bus ();

   key_bit_serializer #(
      .DEB_CYCLES (DEB),
      .DEPTH      (DEPTH)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .KEY_BIT  (KEY_BIT),
      .KEY_PUSH (KEY_PUSH),
      .bus      (bus)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model: a bounded queue ----------------
   bit m_q[$];
   bit m_d, m_dv, m_ovf;

   function automatic void m_reset();
      m_q.delete();
      m_d   = 1'b0;
      m_dv  = 1'b0;
      m_ovf = 1'b0;
   endfunction

   function automatic void m_press(input bit b);
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else                    m_ovf = 1'b1;
   endfunction

   function automatic void m_tick();
      if (m_q.size() > 0) begin
         m_d  = m_q.pop_front();
         m_dv = 1'b1;
      end else begin
         m_d  = 1'b0;
         m_dv = 1'b0;
      end
   endfunction

   task automatic check_model(input string tag);
      check({tag, " D"},        32'(bus.D),        32'(m_d));
      check({tag, " D_VALID"},  32'(bus.D_VALID),  32'(m_dv));
      check({tag, " FIFO_CNT"}, 32'(bus.FIFO_CNT), 32'(m_q.size()));
      check({tag, " EMPTY"},    32'(bus.EMPTY),    32'(m_q.size() == 0));
      check({tag, " FULL"},     32'(bus.FULL),     32'(m_q.size() == DEPTH));
      check({tag, " OVF"},      32'(bus.OVF),      32'(m_ovf));
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST_N    = 1'b0;
      bus.TICK = 1'b0;
      KEY_PUSH = 1'b1;
      KEY_BIT  = 1'b0;
      step(2);
      RST_N = 1'b1;
      step(2);
      m_reset();
   endtask

   // Button goes low just after edge 0; the write lands on edge DEB+3.
   task automatic press_start(input bit b, input bit with_tick);
      step(1);
      KEY_BIT  = b;
      KEY_PUSH = 1'b0;
      step(DEB + 2);
      if (with_tick) bus.TICK = 1'b1;
      step(1);
      bus.TICK = 1'b0;
   endtask

   task automatic press_release();
      step(3);
      KEY_PUSH = 1'b1;
      step(10);
   endtask

   task automatic press(input bit b);
      press_start(b, 1'b0);
      press_release();
   endtask

   task automatic tick();
      bus.TICK = 1'b1;
      step(1);
      bus.TICK = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef enum logic {OP_PRESS, OP_TICK} op_e;
   typedef struct {
      op_e  op;
      logic kbit;
      logic exp_d;
      logic exp_dv;
      int   exp_cnt;
      logic exp_full;
      logic exp_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input op_e op, input logic k, input logic d, input logic dv,
                               input int c, input logic f, input logic o);
      vec_t v;
      v.op = op; v.kbit = k; v.exp_d = d; v.exp_dv = dv;
      v.exp_cnt = c; v.exp_full = f; v.exp_ovf = o;
      vecs.push_back(v);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit bits[DEPTH];
      bit nb;

      bus.TICK = 1'b0;

      // Stream 1,1,0,1 then an idle tick.
      add(OP_PRESS, 1, 0, 0, 1, 0, 0);
      add(OP_PRESS, 1, 0, 0, 2, 0, 0);
      add(OP_PRESS, 0, 0, 0, 3, 0, 0);
      add(OP_PRESS, 1, 0, 0, 4, 0, 0);
      add(OP_TICK,  0, 1, 1, 3, 0, 0);
      add(OP_TICK,  0, 1, 1, 2, 0, 0);
      add(OP_TICK,  0, 0, 1, 1, 0, 0);
      add(OP_TICK,  0, 1, 1, 0, 0, 0);
      add(OP_TICK,  0, 0, 0, 0, 0, 0);
      // Nine presses: 1,0,1,1,0,0,1,0 fill the FIFO, the ninth (1) is dropped.
      add(OP_PRESS, 1, 0, 0, 1, 0, 0);
      add(OP_PRESS, 0, 0, 0, 2, 0, 0);
      add(OP_PRESS, 1, 0, 0, 3, 0, 0);
      add(OP_PRESS, 1, 0, 0, 4, 0, 0);
      add(OP_PRESS, 0, 0, 0, 5, 0, 0);
      add(OP_PRESS, 0, 0, 0, 6, 0, 0);
      add(OP_PRESS, 1, 0, 0, 7, 0, 0);
      add(OP_PRESS, 0, 0, 0, 8, 1, 0);
      add(OP_PRESS, 1, 0, 0, 8, 1, 1);
      // Drain: first eight bits in order, then idle filler.
      add(OP_TICK,  0, 1, 1, 7, 0, 1);
      add(OP_TICK,  0, 0, 1, 6, 0, 1);
      add(OP_TICK,  0, 1, 1, 5, 0, 1);
      add(OP_TICK,  0, 1, 1, 4, 0, 1);
      add(OP_TICK,  0, 0, 1, 3, 0, 1);
      add(OP_TICK,  0, 0, 1, 2, 0, 1);
      add(OP_TICK,  0, 1, 1, 1, 0, 1);
      add(OP_TICK,  0, 0, 1, 0, 0, 1);
      add(OP_TICK,  0, 0, 0, 0, 0, 1);

      // ---- reset state after 20 idle cycles ----
      do_reset();
      step(20);
      check("reset D",        32'(bus.D),        0);
      check("reset D_VALID",  32'(bus.D_VALID),  0);
      check("reset FIFO_CNT", 32'(bus.FIFO_CNT), 0);
      check("reset EMPTY",    32'(bus.EMPTY),    1);
      check("reset FULL",     32'(bus.FULL),     0);
      check("reset OVF",      32'(bus.OVF),      0);

      // ---- press latency and single event while held ----
      step(1);
      KEY_BIT  = 1'b1;
      KEY_PUSH = 1'b0;
      step(DEB + 2);
      check("latency edge6 FIFO_CNT", 32'(bus.FIFO_CNT), 0);
      step(1);
      check("latency edge7 FIFO_CNT", 32'(bus.FIFO_CNT), 1);
      check("latency edge7 EMPTY",    32'(bus.EMPTY),    0);
      step(50);
      check("held FIFO_CNT", 32'(bus.FIFO_CNT), 1);
      KEY_PUSH = 1'b1;
      step(10);
      check("release FIFO_CNT", 32'(bus.FIFO_CNT), 1);
      tick();
      check("first pop D",       32'(bus.D),       1);
      check("first pop D_VALID", 32'(bus.D_VALID), 1);
      check("first pop EMPTY",   32'(bus.EMPTY),   1);
      step(10);
      check("hold D",       32'(bus.D),       1);
      check("hold D_VALID", 32'(bus.D_VALID), 1);

      // ---- bouncing button never qualifies ----
      for (int i = 0; i < 30; i++) begin
         if (i % 2 == 0) KEY_PUSH = ~KEY_PUSH;
         step(1);
      end
      KEY_PUSH = 1'b1;
      step(10);
      check("bounce FIFO_CNT", 32'(bus.FIFO_CNT), 0);
      check("bounce OVF",      32'(bus.OVF),      0);

      // ---- table-driven stream and overflow ----
      do_reset();
      foreach (vecs[i]) begin
         if (vecs[i].op == OP_PRESS) begin
            press(vecs[i].kbit);
         end else begin
            tick();
         end
         check($sformatf("vec%0d D", i),        32'(bus.D),        32'(vecs[i].exp_d));
         check($sformatf("vec%0d D_VALID", i),  32'(bus.D_VALID),  32'(vecs[i].exp_dv));
         check($sformatf("vec%0d FIFO_CNT", i), 32'(bus.FIFO_CNT), 32'(vecs[i].exp_cnt));
         check($sformatf("vec%0d EMPTY", i),    32'(bus.EMPTY),    32'(vecs[i].exp_cnt == 0));
         check($sformatf("vec%0d FULL", i),     32'(bus.FULL),     32'(vecs[i].exp_full));
         check($sformatf("vec%0d OVF", i),      32'(bus.OVF),      32'(vecs[i].exp_ovf));
         if (vecs[i].op == OP_TICK) step(10);
      end

      // ---- asynchronous reset mid-stream (OVF is set here) ----
      press(1'b1);
      press(1'b1);
      tick();
      check("pre-reset D_VALID", 32'(bus.D_VALID), 1);
      @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      check("async reset D",        32'(bus.D),        0);
      check("async reset D_VALID",  32'(bus.D_VALID),  0);
      check("async reset FIFO_CNT", 32'(bus.FIFO_CNT), 0);
      check("async reset EMPTY",    32'(bus.EMPTY),    1);
      check("async reset OVF",      32'(bus.OVF),      0);
      step(1);
      RST_N = 1'b1;
      step(2);

      // ---- asynchronous reset mid-debounce ----
      KEY_PUSH = 1'b0;
      step(4);
      #2;
      RST_N = 1'b0;
      KEY_PUSH = 1'b1;
      step(2);
      RST_N = 1'b1;
      step(20);
      check("mid-debounce reset FIFO_CNT", 32'(bus.FIFO_CNT), 0);

      // ---- press coincident with tick while FULL ----
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         bits[i] = 1'($urandom);
         press(bits[i]);
         m_press(bits[i]);
      end
      check_model("fill");
      nb = ~bits[DEPTH-1];
      press_start(nb, 1'b1);
      m_tick();
      m_press(nb);
      check("full+tick FIFO_CNT", 32'(bus.FIFO_CNT), DEPTH);
      check("full+tick OVF",      32'(bus.OVF),      0);
      check("full+tick D",        32'(bus.D),        32'(bits[0]));
      check_model("full+tick");
      press_release();
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         m_tick();
         check_model($sformatf("drain%0d", i));
      end
      check("new bit as 8th pop", 32'(bus.D), 32'(nb));

      // ---- press coincident with tick while EMPTY ----
      press_start(1'b1, 1'b1);
      m_tick();
      m_press(1'b1);
      check("empty+tick D",        32'(bus.D),        0);
      check("empty+tick D_VALID",  32'(bus.D_VALID),  0);
      check("empty+tick FIFO_CNT", 32'(bus.FIFO_CNT), 1);
      press_release();
      tick();
      m_tick();
      check("empty+tick later D", 32'(bus.D), 1);
      check_model("empty+tick later");

      // ---- random traffic against the queue model ----
      do_reset();
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 99) < 55) begin
            bit b;
            b = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
               repeat ($urandom_range(1, 3)) begin
                  KEY_PUSH = 1'b0;
                  step($urandom_range(1, 2));
                  KEY_PUSH = 1'b1;
                  step(3);
               end
            end
            press(b);
            m_press(b);
         end else begin
            tick();
            m_tick();
         end
         step($urandom_range(0, 3));
         check_model($sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
